// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for an 8:1 shared mux. Grants one requester at a time,
// bounds each grant to MAX_HOLD cycles, and rotates priority past the last
// winner so that every requester gets a turn.
module rr_mux8_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req,
    input  logic [8*DATA_W-1:0] din,
    output logic [7:0]          gnt,
    output logic [2:0]          sel,
    output logic                busy,
    output logic [DATA_W-1:0]   y
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_n;
    logic [7:0]       gnt_n;
    logic [2:0]       sel_n;
    logic [2:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [2:0] win;
    logic [2:0] idx;
    logic       found;

    // Round-robin search: ptr has top priority, then ptr+1 ... ptr+7 (mod 8).
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count/release in GRANT.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n   = win;
                    gnt_n   = 8'b1 << win;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel] || cnt == CNT_LAST) begin
                    gnt_n   = '0;
                    ptr_n   = sel + 3'd1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any active grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    assign busy = |gnt;
    assign y    = busy ? din[32'(sel) * DATA_W +: DATA_W] : '0;

endmodule
